arcade_input_mux: RTL and testbench

Parametrised control front-end for the multicore arcade tops. It replaces the per-game hand wiring of board buttons, connector joysticks, keyboard-mapped controls and the scoreboard toggle. Raw pins are synchronised and debounced per line, then merged with keyboard lanes under swap and one-player modes. Opposing directions are cleaned, a fixed-width coin pulse is generated, and a toggle output is produced, all in the system clock domain between `kbd_joystick` and the game core.

---
 rtl/arcade_input_pkg.sv | 23 ++
 rtl/arcade_debounce.sv | 47 ++++
 rtl/arcade_input_mux.sv | 242 ++++++++++++++++++++++++
 tb/tb_arcade_input_mux.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade control front-end.
package arcade_input_pkg;

  // Lane positions inside one player's bundle.
  localparam int LANE_RIGHT = 0;
  localparam int LANE_LEFT  = 1;
  localparam int LANE_DOWN  = 2;
  localparam int LANE_UP    = 3;
  localparam int LANE_FIRE0 = 4;

  // Coin pulse shaper states.
  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_state_t;

  // Four direction lanes followed by the fire buttons.
  function automatic int lanes_per_player(input int num_fire);
    return 4 + num_fire;
  endfunction

endpackage

// File: rtl/arcade_debounce.sv
// One raw active-low line: 2-FF synchroniser followed by a stability counter.
// Output stays in the raw (active-low) polarity; released = 1.
module arcade_debounce #(
  parameter int DEB_BITS = 9
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic deb_o
);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_state;
  logic [DEB_BITS-1:0] r_cnt;

  // Bring the asynchronous pin into the clk_i domain; released out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= raw_i;
      r_sync2 <= r_sync1;
    end
  end

  // Count cycles of disagreement; flip the state only after a full run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= 1'b1;
      r_cnt   <= '0;
    end else if (r_sync2 != r_state) begin
      if (r_cnt == {DEB_BITS{1'b1}}) begin
        r_state <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DEB_BITS'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign deb_o = r_state;

endmodule

// File: rtl/arcade_input_mux.sv
// Arcade control front-end: debounces connector/board pins, merges them with
// keyboard lanes under swap / one-player modes, cleans opposing directions,
// shapes the coin pulse and drives the scoreboard toggle.
// Optional autofire is built when ARCADE_INPUT_AUTOFIRE_EN is defined.
// coin_state_o exposes the coin FSM state for observation.
module arcade_input_mux
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_FIRE    = 7,
  parameter int DEB_BITS    = 9,
  parameter int COIN_CYCLES = 16384,
  parameter int GAP_CYCLES  = 16384
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  ,
  parameter int AUTOFIRE_HALF = 262144
`endif
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [NUM_PLAYERS*lanes_per_player(NUM_FIRE)-1:0] joy_n_i,
  input  logic [NUM_PLAYERS*lanes_per_player(NUM_FIRE)-1:0] kbd_i,
  input  logic [3:0]                                        btn_n_i,
  input  logic [2:0]                                        kbd_ctrl_i,
  input  logic                                              joyswap_i,
  input  logic                                              oneplayer_i,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic [NUM_FIRE-1:0]                               autofire_i,
`endif
  output logic [NUM_PLAYERS*lanes_per_player(NUM_FIRE)-1:0] player_o,
  output logic [1:0]                                        start_o,
  output logic                                              coin_o,
  output logic                                              reset_req_o,
  output logic                                              toggle_o,
  output coin_state_t                                       coin_state_o
);

  localparam int L        = lanes_per_player(NUM_FIRE);
  localparam int NL       = NUM_PLAYERS * L;
  localparam int TOP_FIRE = LANE_FIRE0 + NUM_FIRE - 1;
  localparam int CNT_MAX  = (COIN_CYCLES > GAP_CYCLES) ? COIN_CYCLES : GAP_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  logic [NL-1:0] w_joy_deb_n;
  logic [3:0]    w_btn_deb_n;
  logic [NL-1:0] w_phys;
  logic [NL-1:0] w_src;
  logic [L-1:0]  w_all;
  logic [L-1:0]  w_lane;
  logic [NL-1:0] w_clean;
  logic [NL-1:0] w_out;
  logic          w_coin_req;
  logic          w_coin_edge;

  logic [NL-1:0]    r_player;
  logic [1:0]       r_start;
  logic             r_reset_req;
  logic             r_top_q;
  logic             r_top_prev;
  logic             r_toggle;
  logic             r_coin_req_prev;
  coin_state_t      r_coin_state;
  logic [CNT_W-1:0] r_coin_cnt;
  logic             r_coin;

  // One debouncer per raw connector line and per board button.
  for (genvar g = 0; g < NL; g++) begin : g_joy_deb
    arcade_debounce #(.DEB_BITS(DEB_BITS)) u_deb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .raw_i (joy_n_i[g]),
      .deb_o (w_joy_deb_n[g])
    );
  end

  for (genvar b = 0; b < 4; b++) begin : g_btn_deb
    arcade_debounce #(.DEB_BITS(DEB_BITS)) u_deb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .raw_i (btn_n_i[b]),
      .deb_o (w_btn_deb_n[b])
    );
  end

  assign w_phys = ~w_joy_deb_n;

  // Port swap only exists when there are at least two ports to exchange.
  if (NUM_PLAYERS >= 2) begin : g_swap
    always_comb begin
      w_src = w_phys;
      if (joyswap_i) begin
        w_src[0 +: L] = w_phys[L +: L];
        w_src[L +: L] = w_phys[0 +: L];
      end
    end
  end else begin : g_noswap
    assign w_src = w_phys;
  end

  // Merge ports with keyboard lanes, then cancel opposing directions.
  always_comb begin
    w_all   = '0;
    w_lane  = '0;
    w_clean = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_all = w_all | w_phys[p*L +: L] | kbd_i[p*L +: L];
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_lane = oneplayer_i ? w_all : (w_src[p*L +: L] | kbd_i[p*L +: L]);
      if (w_lane[LANE_UP] && w_lane[LANE_DOWN]) begin
        w_lane[LANE_UP]   = 1'b0;
        w_lane[LANE_DOWN] = 1'b0;
      end
      if (w_lane[LANE_LEFT] && w_lane[LANE_RIGHT]) begin
        w_lane[LANE_LEFT]  = 1'b0;
        w_lane[LANE_RIGHT] = 1'b0;
      end
      w_clean[p*L +: L] = w_lane;
    end
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int AF_W = $clog2(2 * AUTOFIRE_HALF);

  logic [NL-1:0]          r_clean_prev;
  logic [AF_W-1:0]        r_af_cnt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] w_af_press;
  logic [NUM_PLAYERS-1:0] w_af_high;

  // Chop enabled fires; the press cycle itself is always the high phase.
  always_comb begin
    w_out      = w_clean;
    w_af_press = '0;
    w_af_high  = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_af_press[p] = |(w_clean[p*L+LANE_FIRE0 +: NUM_FIRE]
                        & ~r_clean_prev[p*L+LANE_FIRE0 +: NUM_FIRE] & autofire_i);
      w_af_high[p]  = w_af_press[p] || (r_af_cnt[p] < AF_W'(AUTOFIRE_HALF));
      for (int f = 0; f < NUM_FIRE; f++) begin
        if (autofire_i[f] && !w_af_high[p]) begin
          w_out[p*L+LANE_FIRE0+f] = 1'b0;
        end
      end
    end
  end

  // Per-player phase counter, restarted by a press edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_clean_prev <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) r_af_cnt[p] <= '0;
    end else begin
      r_clean_prev <= w_clean;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (w_af_press[p]) begin
          r_af_cnt[p] <= AF_W'(1);
        end else if (r_af_cnt[p] == AF_W'(2*AUTOFIRE_HALF - 1)) begin
          r_af_cnt[p] <= '0;
        end else begin
          r_af_cnt[p] <= r_af_cnt[p] + AF_W'(1);
        end
      end
    end
  end
`else
  assign w_out = w_clean;
`endif

  assign w_coin_req  = ~w_btn_deb_n[2] | kbd_ctrl_i[2];
  assign w_coin_edge = w_coin_req & ~r_coin_req_prev;

  // Output registers, edge history and the scoreboard toggle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_player        <= '0;
      r_start         <= '0;
      r_reset_req     <= 1'b0;
      r_top_q         <= 1'b0;
      r_top_prev      <= 1'b0;
      r_toggle        <= 1'b0;
      r_coin_req_prev <= 1'b0;
    end else begin
      r_player        <= w_out;
      r_start         <= ~w_btn_deb_n[1:0] | kbd_ctrl_i[1:0];
      r_reset_req     <= ~w_btn_deb_n[3];
      r_top_q         <= w_clean[TOP_FIRE];
      r_top_prev      <= r_top_q;
      r_coin_req_prev <= w_coin_req;
      if (r_top_q && !r_top_prev) r_toggle <= ~r_toggle;
    end
  end

  // Coin shaper: fixed high time, then a forced low gap whose last cycle is
  // spent in COIN_IDLE so a new edge there is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_coin_state <= COIN_IDLE;
      r_coin_cnt   <= '0;
      r_coin       <= 1'b0;
    end else begin
      case (r_coin_state)
        COIN_IDLE: begin
          if (w_coin_edge) begin
            r_coin_state <= COIN_PULSE;
            r_coin_cnt   <= '0;
            r_coin       <= 1'b1;
          end
        end
        COIN_PULSE: begin
          if (r_coin_cnt == CNT_W'(COIN_CYCLES - 1)) begin
            r_coin_cnt   <= '0;
            r_coin       <= 1'b0;
            r_coin_state <= (GAP_CYCLES > 1) ? COIN_GAP : COIN_IDLE;
          end else begin
            r_coin_cnt <= r_coin_cnt + CNT_W'(1);
          end
        end
        COIN_GAP: begin
          if (r_coin_cnt == CNT_W'(GAP_CYCLES - 2)) begin
            r_coin_cnt   <= '0;
            r_coin_state <= COIN_IDLE;
          end else begin
            r_coin_cnt <= r_coin_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_coin_state <= COIN_IDLE;
          r_coin_cnt   <= '0;
          r_coin       <= 1'b0;
        end
      endcase
    end
  end

  assign player_o     = r_player;
  assign start_o      = r_start;
  assign coin_o       = r_coin;
  assign reset_req_o  = r_reset_req;
  assign toggle_o     = r_toggle;
  assign coin_state_o = r_coin_state;

endmodule

// File: tb/tb_arcade_input_mux.sv
// Self-checking bench for arcade_input_mux (2 players, 2 fires, short timers).
module tb_arcade_input_mux;
  import arcade_input_pkg::*;

  localparam int NP = 2;
  localparam int NF = 2;
  localparam int L  = 4 + NF;
  localparam int NL = NP * L;

  logic          clk = 1'b0;
  logic          rst;
  logic [NL-1:0] joy_n;
  logic [NL-1:0] kbd;
  logic [3:0]    btn_n;
  logic [2:0]    kbd_ctrl;
  logic          joyswap;
  logic          oneplayer;
  logic [NL-1:0] player;
  logic [1:0]    start;
  logic          coin;
  logic          reset_req;
  logic          toggle;
  coin_state_t   coin_state;

  int total = 0;
  int bad   = 0;

  logic [NL-1:0] exp_q[$];
  logic [1:0]    exp_start_q[$];

  typedef struct {
    logic [NL-1:0] kbd;
    logic          swap;
    logic          one;
    logic [1:0]    ctrl;
    logic [NL-1:0] exp_player;
    logic [1:0]    exp_start;
  } vec_t;

  vec_t vecs[7];

  arcade_input_mux #(
    .NUM_PLAYERS (NP),
    .NUM_FIRE    (NF),
    .DEB_BITS    (4),
    .COIN_CYCLES (8),
    .GAP_CYCLES  (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .joy_n_i      (joy_n),
    .kbd_i        (kbd),
    .btn_n_i      (btn_n),
    .kbd_ctrl_i   (kbd_ctrl),
    .joyswap_i    (joyswap),
    .oneplayer_i  (oneplayer),
    .player_o     (player),
    .start_o      (start),
    .coin_o       (coin),
    .reset_req_o  (reset_req),
    .toggle_o     (toggle),
    .coin_state_o (coin_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference: per player pick its port (swapped for 0/1), OR keyboard, or
  // OR everything in one-player mode; opposing directions cancel.
  function automatic logic [NL-1:0] model_player(input logic [NL-1:0] ports,
                                                 input logic [NL-1:0] keys,
                                                 input logic swap, input logic one);
    logic [L-1:0]  any_lane;
    logic [L-1:0]  lanes;
    logic [NL-1:0] res;
    int src;
    any_lane = '0;
    res = '0;
    for (int p = 0; p < NP; p++) any_lane = any_lane | ports[p*L +: L] | keys[p*L +: L];
    for (int p = 0; p < NP; p++) begin
      src = (swap && p < 2) ? 1 - p : p;
      lanes = one ? any_lane : (ports[src*L +: L] | keys[p*L +: L]);
      if (lanes[3] && lanes[2]) begin lanes[3] = 1'b0; lanes[2] = 1'b0; end
      if (lanes[1] && lanes[0]) begin lanes[1] = 1'b0; lanes[0] = 1'b0; end
      res[p*L +: L] = lanes;
    end
    return res;
  endfunction

  // Coin request pulses at listed offsets; expectation: high on given windows.
  task automatic coin_run(input string name, input int r0, input int r1, input int r2,
                          input int lo2, input int hi2);
    logic exp_c;
    for (int s = 0; s < 36; s++) begin
      kbd_ctrl[2] = (s == r0) || (s == r1) || (s == r2);
      tick();
      exp_c = ((s + 1) >= 1 && (s + 1) <= 8) || ((s + 1) >= lo2 && (s + 1) <= hi2);
      check(name, 32'(coin), 32'(exp_c));
    end
    kbd_ctrl[2] = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    logic [2:0] tog_exp;
    logic m_toggle;
    logic m_prev;
    logic [NL-1:0] e;
    logic [1:0] es;

    vecs[0] = '{kbd: 12'h008, swap: 0, one: 0, ctrl: 2'b00, exp_player: 12'h008, exp_start: 2'b00};
    vecs[1] = '{kbd: 12'h00C, swap: 0, one: 0, ctrl: 2'b01, exp_player: 12'h000, exp_start: 2'b01};
    vecs[2] = '{kbd: 12'h003, swap: 0, one: 0, ctrl: 2'b10, exp_player: 12'h000, exp_start: 2'b10};
    vecs[3] = '{kbd: 12'h040, swap: 0, one: 1, ctrl: 2'b00, exp_player: 12'h041, exp_start: 2'b00};
    vecs[4] = '{kbd: 12'h08C, swap: 0, one: 1, ctrl: 2'b11, exp_player: 12'h082, exp_start: 2'b11};
    vecs[5] = '{kbd: 12'h010, swap: 1, one: 0, ctrl: 2'b00, exp_player: 12'h010, exp_start: 2'b00};
    vecs[6] = '{kbd: 12'hFFF, swap: 0, one: 0, ctrl: 2'b00, exp_player: 12'hC30, exp_start: 2'b00};

    joy_n = '1; kbd = '0; btn_n = 4'hF; kbd_ctrl = '0; joyswap = 0; oneplayer = 0;
    do_reset();

    // Reset values
    check("rst_player", 32'(player), 0);
    check("rst_start", 32'(start), 0);
    check("rst_coin", 32'(coin), 0);
    check("rst_reset_req", 32'(reset_req), 0);
    check("rst_toggle", 32'(toggle), 0);
    check("rst_coin_state", 32'(coin_state), 32'(COIN_IDLE));

    // Debounce latency on joy bit 0
    joy_n[0] = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (player[0] && n == 0) n = i;
    end
    check("deb_latency", 32'(n), 19);
    joy_n[0] = 1'b1;
    repeat (25) tick();
    check("deb_release", 32'(player), 0);

    // A 10-cycle glitch must not pass
    seen = 1'b0;
    joy_n[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); seen |= player[0]; end
    joy_n[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin tick(); seen |= player[0]; end
    check("deb_glitch", 32'(seen), 0);

    // Board buttons
    btn_n = 4'b0110;
    repeat (22) tick();
    check("btn_reset_req", 32'(reset_req), 1);
    check("btn_start1", 32'(start), 2'b01);
    btn_n = 4'hF;
    repeat (22) tick();
    check("btn_released", 32'({reset_req, start}), 0);

    // Swap and one-player with a physical port
    joyswap = 1'b1;
    joy_n[3] = 1'b0;
    repeat (20) tick();
    check("swap_p1_up", 32'(player), 12'h200);
    oneplayer = 1'b1;
    tick();
    check("oneplayer_up", 32'(player), 12'h208);
    joy_n = '1; joyswap = 0; oneplayer = 0;
    repeat (25) tick();
    check("swap_release", 32'(player), 0);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      kbd = vecs[i].kbd; joyswap = vecs[i].swap; oneplayer = vecs[i].one;
      kbd_ctrl = {1'b0, vecs[i].ctrl};
      tick();
      check($sformatf("vec%0d_player", i), 32'(player), 32'(vecs[i].exp_player));
      check($sformatf("vec%0d_start", i), 32'(start), 32'(vecs[i].exp_start));
    end
    kbd = '0; joyswap = 0; oneplayer = 0; kbd_ctrl = '0;

    // SOCD release
    kbd = 12'h00C;
    tick();
    check("socd_both", 32'(player[3:2]), 0);
    kbd = 12'h008;
    tick();
    check("socd_up", 32'(player[3:2]), 2'b10);
    kbd = '0;

    // Toggle on player 0 fire1
    do_reset();
    tog_exp = 3'b101;
    for (int i = 0; i < 3; i++) begin
      kbd[5] = 1'b1;
      tick();
      check("tog_fire_rise", 32'(player[5]), 1);
      check("tog_hold", 32'(toggle), 32'(i[0]));
      tick();
      check($sformatf("tog_press%0d", i), 32'(toggle), 32'(tog_exp[i]));
      kbd[5] = 1'b0;
      tick();
      tick();
    end

    // Coin: edge at 11 (in gap) dropped, edge at 13 accepted
    coin_run("coin_a", 0, 11, 13, 14, 21);
    // Earliest retrigger edge right at the end of the gap
    coin_run("coin_b", 0, 12, 99, 13, 20);

    // Reset in the 4th cycle of a pulse
    kbd_ctrl[2] = 1'b1;
    tick();
    kbd_ctrl[2] = 1'b0;
    tick(); tick(); tick();
    check("midrst_coin_high", 32'(coin), 1);
    rst = 1'b1;
    kbd = 12'h001; kbd_ctrl = 3'b001;
    tick();
    check("midrst_coin", 32'(coin), 0);
    check("midrst_state", 32'(coin_state), 32'(COIN_IDLE));
    check("midrst_outs", 32'({player, start, reset_req, toggle}), 0);
    rst = 1'b0; kbd = '0; kbd_ctrl = '0;

    // Randomized keyboard/mode traffic against the reference
    do_reset();
    m_toggle = 1'b0;
    m_prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      kbd = NL'($urandom_range(0, 4095));
      joyswap = 1'($urandom_range(0, 1));
      oneplayer = ($urandom_range(0, 3) == 0);
      kbd_ctrl = {1'b0, 2'($urandom_range(0, 3))};
      exp_q.push_back(model_player('0, kbd, joyswap, oneplayer));
      exp_start_q.push_back(kbd_ctrl[1:0]);
      tick();
      e = exp_q.pop_front();
      es = exp_start_q.pop_front();
      check("rand_player", 32'(player), 32'(e));
      check("rand_start", 32'(start), 32'(es));
      check("rand_toggle", 32'(toggle), 32'(m_toggle));
      m_toggle = m_toggle ^ (e[L-1] & ~m_prev);
      m_prev = e[L-1];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
